// File: rtl/instr_encoder_loader.sv
// instr_encoder_loader
//   Packs symbolic instructions (opcode + register/immediate fields) into
//   INSTR_W-bit words, buffers them in a DEPTH-entry FIFO and writes them
//   sequentially into instruction memory starting at address 0.
//
//   Optional feature macro: INSTR_ENCODER_NOP_PAD_EN
//     defined   : after HALT is written, the rest of memory up to the last
//                 address is filled with all-zero (NOP) words.
//     undefined : the load finishes as soon as HALT is written.
//
// Ports
//   clk, rst_n          clock, synchronous active-low reset
//   start               one-cycle pulse, begins a fresh load at address 0
//   in_valid/in_ready   instruction stream handshake
//   in_opcode, in_rs, in_rt, in_rd, in_imm   symbolic instruction fields
//   imem_we/addr/wdata  registered memory write port
//   imem_ready          memory accepts the write this cycle
//   busy, done          load in progress / program fully written (sticky)
//   err_opcode          invalid opcode seen (sticky)
//   err_overflow        program exceeded memory (sticky)
//   words_written       count of committed words
//
// state    | meaning
// ---------+-------------------------------------------------------------
// ST_IDLE  | after reset, waiting for start
// ST_LOAD  | accepting instructions, writing FIFO head to memory
// ST_DRAIN | HALT accepted, writing out remaining words (and NOP padding)
// ST_DONE  | program written, waiting for start
// ST_ERROR | memory overflow, FIFO flushed, waiting for start

module instr_encoder_loader #(
    parameter int INSTR_W = 32,
    parameter int REG_W   = 5,
    parameter int IMM_W   = 18,   // must equal INSTR_W-4-2*REG_W
    parameter int ADDR_W  = 8,
    parameter int DEPTH   = 4     // power of two, >= 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [3:0]         in_opcode,
    input  logic [REG_W-1:0]   in_rs,
    input  logic [REG_W-1:0]   in_rt,
    input  logic [REG_W-1:0]   in_rd,
    input  logic [IMM_W-1:0]   in_imm,
    output logic               imem_we,
    output logic [ADDR_W-1:0]  imem_addr,
    output logic [INSTR_W-1:0] imem_wdata,
    input  logic               imem_ready,
    output logic               busy,
    output logic               done,
    output logic               err_opcode,
    output logic               err_overflow,
    output logic [ADDR_W:0]    words_written
);

`ifdef INSTR_ENCODER_NOP_PAD_EN
    localparam bit PAD_EN = 1'b1;
`else
    localparam bit PAD_EN = 1'b0;
`endif

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    localparam logic [3:0] OP_NOP  = 4'b0000;
    localparam logic [3:0] OP_ADD  = 4'b0001;
    localparam logic [3:0] OP_MUL  = 4'b0010;
    localparam logic [3:0] OP_SINN = 4'b0011;
    localparam logic [3:0] OP_MAC  = 4'b0100;
    localparam logic [3:0] OP_ADDI = 4'b1001;
    localparam logic [3:0] OP_HALT = 4'b1011;
    localparam logic [3:0] OP_LD   = 4'b1110;
    localparam logic [3:0] OP_ST   = 4'b1111;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_DRAIN,
        ST_DONE,
        ST_ERROR
    } state_t;

    state_t               state_q, state_d;
    logic [INSTR_W-1:0]   fifo_mem_q [DEPTH];
    logic [INSTR_W-1:0]   fifo_mem_d [DEPTH];
    logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]     count_q, count_d;
    logic                 imem_we_q, imem_we_d;
    logic [ADDR_W-1:0]    imem_addr_q, imem_addr_d;
    logic [INSTR_W-1:0]   imem_wdata_q, imem_wdata_d;
    logic [ADDR_W:0]      words_written_q, words_written_d;
    logic                 err_opcode_q, err_opcode_d;
    logic                 err_overflow_q, err_overflow_d;
    logic                 pad_q, pad_d;

    logic                 op_valid;
    logic [INSTR_W-1:0]   packed_word;
    logic                 xfer, push, pop, commit, flush;
    logic                 head_is_halt, at_last_addr;
    logic [CNT_W-1:0]     count_after_pop;

    // Field packing. NOP stays all-zero whatever its fields carry.
    always_comb begin
        op_valid    = 1'b0;
        packed_word = '0;
        case (in_opcode)
            OP_NOP: begin
                op_valid = 1'b1;
            end
            OP_ADD, OP_MUL, OP_SINN, OP_MAC: begin
                op_valid                                   = 1'b1;
                packed_word[INSTR_W-1 -: 4]                = in_opcode;
                packed_word[INSTR_W-5 -: REG_W]            = in_rs;
                packed_word[INSTR_W-5-REG_W -: REG_W]      = in_rt;
                packed_word[INSTR_W-5-2*REG_W -: REG_W]    = in_rd;
            end
            OP_ADDI, OP_LD, OP_ST: begin
                op_valid                                   = 1'b1;
                packed_word[INSTR_W-1 -: 4]                = in_opcode;
                packed_word[INSTR_W-5 -: REG_W]            = in_rs;
                packed_word[INSTR_W-5-REG_W -: REG_W]      = in_rt;
                packed_word[IMM_W-1:0]                     = in_imm;
            end
            OP_HALT: begin
                op_valid                    = 1'b1;
                packed_word[INSTR_W-1 -: 4] = in_opcode;
            end
            default: begin
                op_valid = 1'b0;
            end
        endcase
    end

    assign in_ready = (state_q == ST_LOAD) && (count_q != CNT_W'(DEPTH));
    assign xfer     = in_valid && in_ready;
    assign push     = xfer && op_valid;
    assign commit   = imem_we_q && imem_ready;
    // Padding words are generated here, not taken from the FIFO.
    assign pop      = commit && !pad_q;

    assign head_is_halt    = (imem_wdata_q[INSTR_W-1 -: 4] == OP_HALT);
    assign at_last_addr    = &imem_addr_q;
    assign count_after_pop = count_q - CNT_W'(pop);

    always_comb begin
        state_d         = state_q;
        fifo_mem_d      = fifo_mem_q;
        wr_ptr_d        = wr_ptr_q;
        rd_ptr_d        = rd_ptr_q;
        count_d         = count_q;
        imem_addr_d     = imem_addr_q;
        words_written_d = words_written_q;
        err_opcode_d    = err_opcode_q;
        err_overflow_d  = err_overflow_q;
        pad_d           = pad_q;
        flush           = 1'b0;

        case (state_q)
            ST_IDLE, ST_DONE, ST_ERROR: begin
                if (start) begin
                    state_d         = ST_LOAD;
                    flush           = 1'b1;
                    imem_addr_d     = '0;
                    words_written_d = '0;
                    err_opcode_d    = 1'b0;
                    err_overflow_d  = 1'b0;
                    pad_d           = 1'b0;
                end
            end
            ST_LOAD: begin
                if (xfer && !op_valid) begin
                    err_opcode_d = 1'b1;
                end
                if (push && (in_opcode == OP_HALT)) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (push) begin
            fifo_mem_d[wr_ptr_q] = packed_word;
            wr_ptr_d             = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        count_d = count_q + CNT_W'(push) - CNT_W'(pop);

        if (commit) begin
            imem_addr_d     = imem_addr_q + ADDR_W'(1);
            words_written_d = words_written_q + (ADDR_W+1)'(1);
            if (pad_q) begin
                if (at_last_addr) begin
                    state_d = ST_DONE;
                    pad_d   = 1'b0;
                end
            end else if (head_is_halt) begin
                if (PAD_EN && !at_last_addr) begin
                    pad_d = 1'b1;
                end else begin
                    state_d = ST_DONE;
                end
            end else if (at_last_addr) begin
                // The next write would wrap onto address 0.
                err_overflow_d = 1'b1;
                state_d        = ST_ERROR;
                flush          = 1'b1;
            end
        end

        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end
    end

    // Registered write port: next-cycle view of the FIFO head. When the FIFO
    // empties this cycle, the word being pushed becomes the new head.
    always_comb begin
        imem_we_d    = ((state_d == ST_LOAD) || (state_d == ST_DRAIN)) &&
                       ((count_d != '0) || pad_d);
        imem_wdata_d = '0;
        if (imem_we_d && !pad_d) begin
            if (count_after_pop == '0) begin
                imem_wdata_d = packed_word;
            end else begin
                imem_wdata_d = fifo_mem_q[rd_ptr_d];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q         <= ST_IDLE;
            wr_ptr_q        <= '0;
            rd_ptr_q        <= '0;
            count_q         <= '0;
            imem_we_q       <= 1'b0;
            imem_addr_q     <= '0;
            imem_wdata_q    <= '0;
            words_written_q <= '0;
            err_opcode_q    <= 1'b0;
            err_overflow_q  <= 1'b0;
            pad_q           <= 1'b0;
        end else begin
            state_q         <= state_d;
            wr_ptr_q        <= wr_ptr_d;
            rd_ptr_q        <= rd_ptr_d;
            count_q         <= count_d;
            imem_we_q       <= imem_we_d;
            imem_addr_q     <= imem_addr_d;
            imem_wdata_q    <= imem_wdata_d;
            words_written_q <= words_written_d;
            err_opcode_q    <= err_opcode_d;
            err_overflow_q  <= err_overflow_d;
            pad_q           <= pad_d;
        end
    end

    // Storage only; validity is tracked by the pointers and count.
    always_ff @(posedge clk) begin
        fifo_mem_q <= fifo_mem_d;
    end

    assign imem_we       = imem_we_q;
    assign imem_addr     = imem_addr_q;
    assign imem_wdata    = imem_wdata_q;
    assign words_written = words_written_q;
    assign err_opcode    = err_opcode_q;
    assign err_overflow  = err_overflow_q;
    assign busy          = (state_q == ST_LOAD) || (state_q == ST_DRAIN);
    assign done          = (state_q == ST_DONE);

endmodule
